// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and defaults for the branch resolve unit
//
// Purpose: branch type encoding, FSM state encoding and default widths
//          shared by branch_target_calc and branch_resolve_unit.
// Ports:   none (package).
package branch_pkg;

  localparam int PC_W_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_J    = 2'd3
  } br_type_t;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } fsm_state_t;

  function automatic logic is_branch(input br_type_t t);
    return t != BR_NONE;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational branch decision and target adder
//
// Purpose: decides whether the EX-stage branch/jump is taken and computes
//          its redirect address.
// Ports:
//   i_br_type   branch type (branch_pkg::br_type_t encoding)
//   i_zero      ALU result is zero
//   i_pc_plus4  PC+4 of the EX instruction
//   i_imm       sign-extended 16-bit word offset
//   i_jaddr     jump instruction index field
//   o_taken     branch/jump is taken
//   o_target    redirect address
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [1:0]      i_br_type,
  input  logic            i_zero,
  input  logic [PC_W-1:0] i_pc_plus4,
  input  logic [31:0]     i_imm,
  input  logic [25:0]     i_jaddr,
  output logic            o_taken,
  output logic [PC_W-1:0] o_target
);

  br_type_t               w_type;
  logic signed [PC_W-1:0] w_imm_ext;
  logic [PC_W-1:0]        w_br_target;
  logic [PC_W-1:0]        w_j_target;

  assign w_type = br_type_t'(i_br_type);

  // Sign-extend the word offset to PC width before scaling to bytes;
  // the sum wraps modulo 2^PC_W.
  assign w_imm_ext   = PC_W'($signed(i_imm));
  assign w_br_target = i_pc_plus4 + PC_W'(w_imm_ext <<< 2);

  // Jumps keep the upper PC bits of the delay-slot address (region select).
  assign w_j_target  = {i_pc_plus4[PC_W-1:28], i_jaddr, 2'b00};

  always_comb begin
    o_taken  = 1'b0;
    o_target = w_br_target;
    case (w_type)
      BR_BEQ:  o_taken = i_zero;
      BR_BNE:  o_taken = ~i_zero;
      BR_J: begin
        o_taken  = 1'b1;
        o_target = w_j_target;
      end
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX/MEM branch register, redirect FSM and stats
//
// Purpose: captures resolved branches into the EX/MEM branch register, drives
//          the PC redirect and pipeline flush strobes from it, and keeps
//          saturating branch / taken-branch counters.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_ex_valid          EX holds a real instruction
//   i_ex_br_type        branch type of the EX instruction
//   i_ex_zero           ALU zero flag
//   i_ex_pc_plus4       PC+4 of the EX instruction
//   i_ex_imm            sign-extended word offset
//   i_ex_jaddr          jump index field
//   i_mem_stall         MEM stalled, pipeline registers hold
//   o_pc_sel            fetch from o_branch_target next cycle
//   o_branch_target     redirect address (0 when not redirecting)
//   o_flush_ifid/idex/exmem  squash strobes
//   o_br_count          resolved branches/jumps (saturating)
//   o_taken_count       taken branches/jumps (saturating)
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ex_valid,
  input  logic [1:0]       i_ex_br_type,
  input  logic             i_ex_zero,
  input  logic [PC_W-1:0]  i_ex_pc_plus4,
  input  logic [31:0]      i_ex_imm,
  input  logic [25:0]      i_ex_jaddr,
  input  logic             i_mem_stall,
  output logic             o_pc_sel,
  output logic [PC_W-1:0]  o_branch_target,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_flush_exmem,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fsm_state_t       r_state;
  logic             r_valid;
  logic             r_taken;
  logic [PC_W-1:0]  r_target;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_taken_count;

  logic             w_taken;
  logic [PC_W-1:0]  w_target;
  logic             w_redirect;
  logic             w_capture;

  branch_target_calc #(
    .PC_W (PC_W)
  ) u_target_calc (
    .i_br_type  (i_ex_br_type),
    .i_zero     (i_ex_zero),
    .i_pc_plus4 (i_ex_pc_plus4),
    .i_imm      (i_ex_imm),
    .i_jaddr    (i_ex_jaddr),
    .o_taken    (w_taken),
    .o_target   (w_target)
  );

  assign w_redirect = r_valid & r_taken;

  // The EX instruction is wrong-path while a redirect is out, so it is
  // neither captured nor counted; the redirect always wins.
  assign w_capture  = i_ex_valid & is_branch(br_type_t'(i_ex_br_type)) &
                      ~i_mem_stall & ~w_redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= RUN;
      r_valid       <= 1'b0;
      r_taken       <= 1'b0;
      r_target      <= '0;
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else if (!i_mem_stall) begin
      // Unstalled cycle: load the register, clearing valid if nothing captured.
      r_valid  <= w_capture;
      r_taken  <= w_capture & w_taken;
      r_target <= w_target;

      case (r_state)
        RUN:      if (w_capture && w_taken) r_state <= REDIRECT;
        REDIRECT: r_state <= RUN;
        default:  r_state <= RUN;
      endcase

      if (w_capture) begin
        if (r_br_count != CNT_MAX) r_br_count <= r_br_count + 1'b1;
        if (w_taken && (r_taken_count != CNT_MAX)) begin
          r_taken_count <= r_taken_count + 1'b1;
        end
      end
    end
  end

  assign o_pc_sel        = w_redirect;
  assign o_flush_ifid    = w_redirect;
  assign o_flush_idex    = w_redirect;
  assign o_flush_exmem   = w_redirect;
  assign o_branch_target = w_redirect ? r_target : '0;
  assign o_br_count      = r_br_count;
  assign o_taken_count   = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int PC_W  = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             ex_valid;
  logic [1:0]       ex_br_type;
  logic             ex_zero;
  logic [PC_W-1:0]  ex_pc_plus4;
  logic [31:0]      ex_imm;
  logic [25:0]      ex_jaddr;
  logic             mem_stall;
  logic             pc_sel;
  logic [PC_W-1:0]  branch_target;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ex_valid      (ex_valid),
    .i_ex_br_type    (ex_br_type),
    .i_ex_zero       (ex_zero),
    .i_ex_pc_plus4   (ex_pc_plus4),
    .i_ex_imm        (ex_imm),
    .i_ex_jaddr      (ex_jaddr),
    .i_mem_stall     (mem_stall),
    .o_pc_sel        (pc_sel),
    .o_branch_target (branch_target),
    .o_flush_ifid    (flush_ifid),
    .o_flush_idex    (flush_idex),
    .o_flush_exmem   (flush_exmem),
    .o_br_count      (br_count),
    .o_taken_count   (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  t;
    logic        z;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [25:0] ja;
    logic        e_sel;
    logic [31:0] e_tgt;
    logic [7:0]  e_br;
    logic [7:0]  e_tk;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [31:0] tgt;
    logic [7:0]  br;
    logic [7:0]  tk;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic z,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [25:0] ja, input logic stall);
    ex_valid    = v;
    ex_br_type  = t;
    ex_zero     = z;
    ex_pc_plus4 = pc;
    ex_imm      = imm;
    ex_jaddr    = ja;
    mem_stall   = stall;
  endtask

  task automatic chk_out(input string name, input logic sel, input logic [31:0] tgt,
                         input logic [7:0] br, input logic [7:0] tk);
    chk({name, ".strobes"}, {60'd0, pc_sel, flush_ifid, flush_idex, flush_exmem}, {60'd0, {4{sel}}});
    chk({name, ".target"}, {32'd0, branch_target}, {32'd0, tgt});
    chk({name, ".br_count"}, {56'd0, br_count}, {56'd0, br});
    chk({name, ".taken_count"}, {56'd0, taken_count}, {56'd0, tk});
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] t, input logic z,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [25:0] ja, input logic e_sel,
                              input logic [31:0] e_tgt, input logic [7:0] e_br,
                              input logic [7:0] e_tk);
    vec_t r;
    r.v = v; r.t = t; r.z = z; r.pc = pc; r.imm = imm; r.ja = ja;
    r.e_sel = e_sel; r.e_tgt = e_tgt; r.e_br = e_br; r.e_tk = e_tk;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 32'h104, 32'h3, 26'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 26'd0, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   sel_cycles;

    // Expected outputs one cycle after each vector is presented in EX.
    vecs[0]  = mk(1, 2'd1, 1, 32'h0000_0104, 32'h0000_0003, 26'h0,       1, 32'h0000_0110, 1, 1);
    vecs[1]  = mk(1, 2'd1, 1, 32'h0000_0104, 32'h0000_0003, 26'h0,       0, 32'h0,         1, 1);
    vecs[2]  = mk(1, 2'd2, 1, 32'h0000_0010, 32'hFFFF_FFFE, 26'h0,       0, 32'h0,         2, 1);
    vecs[3]  = mk(1, 2'd2, 0, 32'h0000_0010, 32'hFFFF_FFFE, 26'h0,       1, 32'h0000_0008, 3, 2);
    vecs[4]  = mk(1, 2'd0, 1, 32'h0000_0020, 32'h0000_0001, 26'h0,       0, 32'h0,         3, 2);
    vecs[5]  = mk(1, 2'd3, 0, 32'h4000_0000, 32'h0,         26'h40,      1, 32'h4000_0100, 4, 3);
    vecs[6]  = mk(0, 2'd1, 1, 32'h0000_0104, 32'h0000_0003, 26'h0,       0, 32'h0,         4, 3);
    vecs[7]  = mk(0, 2'd1, 1, 32'h0000_0104, 32'h0000_0003, 26'h0,       0, 32'h0,         4, 3);
    vecs[8]  = mk(1, 2'd0, 1, 32'h0000_0104, 32'h0000_0003, 26'h0,       0, 32'h0,         4, 3);
    vecs[9]  = mk(1, 2'd1, 0, 32'h0000_0104, 32'h0000_0003, 26'h0,       0, 32'h0,         5, 3);
    vecs[10] = mk(1, 2'd2, 0, 32'h0000_1000, 32'h0000_0010, 26'h0,       1, 32'h0000_1040, 6, 4);
    vecs[11] = mk(0, 2'd0, 0, 32'h0,         32'h0,         26'h0,       0, 32'h0,         6, 4);
    vecs[12] = mk(1, 2'd3, 1, 32'hF000_0004, 32'h0,         26'h3FF_FFFF, 1, 32'hFFFF_FFFC, 7, 5);
    vecs[13] = mk(0, 2'd0, 0, 32'h0,         32'h0,         26'h0,       0, 32'h0,         7, 5);
    vecs[14] = mk(1, 2'd1, 1, 32'hFFFF_FFFC, 32'h0000_0001, 26'h0,       1, 32'h0000_0000, 8, 6);
    vecs[15] = mk(0, 2'd0, 0, 32'h0,         32'h0,         26'h0,       0, 32'h0,         8, 6);

    // Reset held two cycles with a taken BEQ in EX.
    rst = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 32'h104, 32'h3, 26'd0, 1'b0);
    step();
    chk_out("reset_c1", 0, 32'h0, 8'd0, 8'd0);
    step();
    chk_out("reset_c2", 0, 32'h0, 8'd0, 8'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 26'd0, 1'b0);

    // Table-driven sequence through the scoreboard.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].t, vecs[i].z, vecs[i].pc, vecs[i].imm, vecs[i].ja, 1'b0);
      e.sel = vecs[i].e_sel;
      e.tgt = vecs[i].e_tgt;
      e.br  = vecs[i].e_br;
      e.tk  = vecs[i].e_tk;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      chk_out($sformatf("vec%0d", i), e.sel, e.tgt, e.br, e.tk);
    end

    // Stall before capture, then taken BEQ held through 3 stall cycles,
    // with a taken branch sitting in EX the whole time.
    do_reset();
    drive(1'b1, 2'd1, 1'b1, 32'h104, 32'h3, 26'd0, 1'b1);
    step();
    chk_out("stall_nocap", 0, 32'h0, 8'd0, 8'd0);
    mem_stall = 1'b0;
    sel_cycles = 0;
    step();
    if (pc_sel) sel_cycles++;
    chk_out("stall_cap", 1, 32'h110, 8'd1, 8'd1);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (pc_sel) sel_cycles++;
      chk_out($sformatf("stall_hold%0d", i), 1, 32'h110, 8'd1, 8'd1);
    end
    mem_stall = 1'b0;
    step();
    if (pc_sel) sel_cycles++;
    chk_out("stall_release", 0, 32'h0, 8'd1, 8'd1);
    chk("stall_sel_cycles", 64'(sel_cycles), 64'd4);
    step();
    chk_out("after_shadow_capture", 1, 32'h110, 8'd2, 8'd2);

    // Reset asserted mid-redirect (while stalled) cancels it.
    do_reset();
    drive(1'b1, 2'd3, 1'b0, 32'h4000_0000, 32'h0, 26'h40, 1'b0);
    step();
    chk_out("pre_rst_redirect", 1, 32'h4000_0100, 8'd1, 8'd1);
    rst = 1'b1;
    mem_stall = 1'b1;
    step();
    chk_out("mid_redirect_rst", 0, 32'h0, 8'd0, 8'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 26'd0, 1'b0);

    // Saturation: 2^CNT_W + 2 taken branches, each followed by a bubble.
    do_reset();
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      drive(1'b1, 2'd1, 1'b1, 32'h104, 32'h3, 26'd0, 1'b0);
      step();
      drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 26'd0, 1'b0);
      step();
      if (i == (1 << CNT_W) - 2) begin
        chk("sat_before_br", {56'd0, br_count}, 64'hFF);
        chk("sat_before_tk", {56'd0, taken_count}, 64'hFF);
      end
    end
    chk("sat_br", {56'd0, br_count}, 64'hFF);
    chk("sat_tk", {56'd0, taken_count}, 64'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
